// File: rtl/shift_io_expander.sv
// shift_io_expander: full-duplex frame controller for a 595 output chain and a 165 input chain on one shift clock.
module shift_io_expander #(
  parameter int OUT_WIDTH = 16,
  parameter int IN_WIDTH  = 21,
  parameter int CLK_DIV   = 10,
  parameter int LSB_FIRST = 0
) (
  input  logic                 i_CLK,
  input  logic                 i_SYS_RESET,
  input  logic                 i_Start,
  input  logic                 i_AutoRefresh,
  input  logic [OUT_WIDTH-1:0] i_OutData,
  output logic [IN_WIDTH-1:0]  o_InData,
  output logic                 o_Busy,
  output logic                 o_Done,
  output logic                 o_SCLK,
  output logic                 o_SDO,
  input  logic                 i_SDI,
  output logic                 o_OutLatch,
  output logic                 o_InLoad
);
  localparam int N  = OUT_WIDTH > IN_WIDTH ? OUT_WIDTH : IN_WIDTH;
  localparam int TW = $clog2(CLK_DIV + 1);
  localparam int KW = $clog2(N + 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [KW-1:0] K_IN   = KW'(IN_WIDTH);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [KW-1:0] k_q, k_d;
  logic [N-1:0] osr_q, osr_d, pad, rev;
  logic [IN_WIDTH-1:0] isr_q, isr_d, in_data_q, in_data_d;
  logic sclk_q, sclk_d, sdo_q, sdo_d, latch_q, latch_d, load_n_q, load_n_d;
  logic busy_q, busy_d, done_q, done_d, phase_end;
  // osr bit 0 is always the next bit on o_SDO; padding zeros sit in the low bits so they go out first
  always_comb begin
    pad = N'(i_OutData);
    for (int i = 0; i < N; i++) rev[i] = pad[N-1-i];
    phase_end = tick_q == T_LAST;
    state_d = state_q;
    k_d = k_q;
    osr_d = osr_q;
    isr_d = isr_q;
    tick_d = (state_q == IDLE || state_q == DONE || phase_end) ? '0 : tick_q + 1'b1;
    case (state_q)
      IDLE: if (i_Start | i_AutoRefresh) begin
        state_d = LOAD;
        k_d = '0;
        osr_d = LSB_FIRST != 0 ? pad << (N - OUT_WIDTH) : rev;
      end
      LOAD: if (phase_end) state_d = SHIFT_LO;
      SHIFT_LO: if (phase_end) begin
        state_d = SHIFT_HI;
        if (k_q < K_IN)
          isr_d = LSB_FIRST != 0 ? IN_WIDTH'({i_SDI, isr_q} >> 1) : IN_WIDTH'({isr_q, i_SDI});
      end
      SHIFT_HI: if (phase_end) begin
        state_d = k_q == K_LAST ? LATCH : SHIFT_LO;
        k_d = k_q + 1'b1;
        osr_d = osr_q >> 1;
      end
      LATCH: if (phase_end) state_d = DONE;
      default: state_d = IDLE;
    endcase
    in_data_d = state_d == DONE ? isr_q : in_data_q;
    sclk_d = state_d == SHIFT_HI;
    sdo_d = (state_d == SHIFT_LO || state_d == SHIFT_HI) ? osr_d[0] : 1'b0;
    latch_d = state_d == LATCH;
    load_n_d = state_d != LOAD;
    busy_d = state_d != IDLE && state_d != DONE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge i_CLK) begin
    if (i_SYS_RESET) begin
      state_q <= IDLE;
      tick_q <= '0;
      k_q <= '0;
      osr_q <= '0;
      isr_q <= '0;
      in_data_q <= '0;
      sclk_q <= 1'b0;
      sdo_q <= 1'b0;
      latch_q <= 1'b0;
      load_n_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      k_q <= k_d;
      osr_q <= osr_d;
      isr_q <= isr_d;
      in_data_q <= in_data_d;
      sclk_q <= sclk_d;
      sdo_q <= sdo_d;
      latch_q <= latch_d;
      load_n_q <= load_n_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign o_InData = in_data_q;
  assign o_Busy = busy_q;
  assign o_Done = done_q;
  assign o_SCLK = sclk_q;
  assign o_SDO = sdo_q;
  assign o_OutLatch = latch_q;
  assign o_InLoad = load_n_q;
endmodule

// File: doc/shift_io_expander.md
# shift_io_expander

Parametrised serial I/O expander controller. It drives a chain of serial-in/parallel-out output registers (595-style: LEDs, segments) and a chain of parallel-in/serial-out input registers (165-style: DIP switches, push buttons) from one shared shift clock. Each frame loads the input chain, shifts both chains full-duplex, and then latches the output chain. It replaces the separate fixed-width LED and DIP drivers in the top level, adding programmable width, clock rate, bit order, a start/done handshake and free-running refresh.

## Interface
- OUT_WIDTH, 16: bits in the output chain (≥1).
- IN_WIDTH, 21: bits in the input chain (≥1).
- CLK_DIV, 10: i_CLK cycles per half-period of o_SCLK (≥1). Also the width of the load and latch pulses.
- LSB_FIRST, 0: 0 shifts MSB first; 1 shifts LSB first. Applies to both directions.

Ports (name, direction, width, meaning):
- i_CLK, in, 1: sole clock. All logic runs on the rising edge.
- i_SYS_RESET, in, 1: synchronous, active-high reset.
- i_Start, in, 1: request one frame. Sampled only in IDLE.
- i_AutoRefresh, in, 1: when 1, frames run back-to-back without i_Start.
- i_OutData, in, OUT_WIDTH: parallel data for the output chain. Captured at frame start.
- o_InData, out, IN_WIDTH: last complete input-chain snapshot.
- o_Busy, out, 1: high from frame start through the LATCH state.
- o_Done, out, 1: one-cycle pulse when o_InData is updated.
- o_SCLK, out, 1: shift clock to both chains.
- o_SDO, out, 1: serial data to the output chain.
- i_SDI, in, 1: serial data from the input chain.
- o_OutLatch, out, 1: output-chain storage clock. Active-high pulse.
- o_InLoad, out, 1: input-chain shift/load. Driven 0 to load parallel inputs, 1 to shift.

## Operation
- N = max(OUT_WIDTH, IN_WIDTH) shift cycles per frame.
- A tick counter counts 0..CLK_DIV-1. Each phase below lasts exactly CLK_DIV i_CLK cycles.
- The FSM states are IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH and DONE.
- IDLE:
  - o_SCLK=0, o_InLoad=1, o_OutLatch=0, o_Busy=0.
  - On (i_Start | i_AutoRefresh), capture i_OutData into the output shift register, set o_Busy=1 and go to LOAD.
- LOAD:
  - o_InLoad=0 for one phase, then go to SHIFT_LO with bit index k=0.
- SHIFT_LO(k):
  - o_SCLK=0.
  - o_SDO presents output bit k from the start of the phase.
  - On the last cycle of the phase, if k < IN_WIDTH, sample i_SDI into input bit k.
  - Then go to SHIFT_HI.
- SHIFT_HI(k):
  - o_SCLK=1 and o_SDO is held.
  - At the end of the phase: if k = N-1, go to LATCH; otherwise k++ and go to SHIFT_LO.
- Output bit order:
  - The first N-OUT_WIDTH shifted bits are 0 (padding; these fall off the far end of the chain).
  - The remaining bits are i_OutData in MSB→LSB order, or LSB→MSB when LSB_FIRST=1.
- Input bit order:
  - The first IN_WIDTH samples are assigned to bits IN_WIDTH-1 down to 0, or 0 up to IN_WIDTH-1 when LSB_FIRST=1.
  - Samples with k ≥ IN_WIDTH are discarded.
- LATCH:
  - o_SCLK=0, o_OutLatch=1 for one phase, then go to DONE.
- DONE (1 cycle):
  - o_InData is loaded from the input shift register and o_Done=1.
  - o_Busy=0, then return to IDLE.
- i_Start received while busy is ignored and not queued.
- Changes to i_OutData mid-frame take effect only in the next frame.
- Reset (any state, including mid-frame):
  - State returns to IDLE.
  - o_SCLK=0, o_SDO=0, o_InLoad=1, o_OutLatch=0, o_Busy=0, o_Done=0, o_InData=0.
  - Counters and shift registers are cleared.
  - A frame interrupted by reset produces no o_OutLatch pulse and no o_Done.
- Counter widths: tick counter is $clog2(CLK_DIV+1) bits; bit index is $clog2(N+1) bits. No wrap occurs within a frame.

## Timing
- Frame latency: with start accepted in IDLE at cycle 0, o_Done is high in cycle CLK_DIV·(2N+2)+1.
- Exactly N rising edges of o_SCLK occur per frame.
- Each o_SDO change coincides with an o_SCLK falling edge, or with LOAD→SHIFT_LO entry. It is stable CLK_DIV cycles before each rising edge.
- i_SDI is sampled one i_CLK cycle before each o_SCLK rising edge.
- o_InLoad returns high CLK_DIV cycles before the first sample.
- o_OutLatch rises CLK_DIV cycles after the last o_SCLK rising edge.
- Auto-refresh frame period is CLK_DIV·(2N+2)+2 cycles: the DONE cycle plus one IDLE cycle.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Reset: hold i_SYS_RESET for 3 cycles → o_SCLK=0, o_SDO=0, o_InLoad=1, o_OutLatch=0, o_Busy=0, o_Done=0, o_InData=0.
- Single frame with OUT_WIDTH=16, IN_WIDTH=21, CLK_DIV=2, i_OutData=16'h5E8A, driven against a 595-chain model → exactly 21 o_SCLK rises. Chain parallel output reads 16'h5E8A after the o_OutLatch pulse. o_Done occurs in cycle 89.
- Input capture: 165-chain model preloaded with 21'h1A5F3C → o_InData=21'h1A5F3C at o_Done. Only the first 21 samples are used.
- LSB_FIRST=1 with the same stimulus → both chain models are still correct (models configured LSB-first). The o_SDO sequence is the reverse of the MSB-first run, excluding the 5 leading padding zeros, which remain first.
- Auto-refresh and handshake:
  - Set i_AutoRefresh=1, pulse i_Start mid-frame, and change i_OutData to 16'h00FF at bit 8.
  - Required: frames every 90 cycles with no extra frame caused by the i_Start pulse.
  - First frame latches 16'h5E8A; second frame latches 16'h00FF.
- Reset mid-frame at k=10 → no o_OutLatch and no o_Done; o_InData=0. The next i_Start completes a normal frame in 89 cycles.
